// File: rtl/fas_peak_scheduler_if.sv
// ---------------------------------------------------------------------------
// fas_peak_scheduler_if
// Bundle between the FAS peak scheduler, the FFT front end, the 16-bin
// squared-magnitude buffer array and the downstream frequency-decision logic.
//
// Signals:
//   fft_valid  - FFT frame valid strobe (into the scheduler)
//   fft_ready  - scheduler can accept a frame (IDLE only)
//   buf_enable - one-cycle enable pulse to the buffer array
//   buf_done   - buffer array done flag
//   sum_bus    - NBINS packed sums, bin k at [SUM_W*k +: SUM_W]
//   tag_bus    - NBINS packed 4-bit tags, bin k at [4k +: 4]
//   peak_valid - one-cycle pulse, peak_tag/peak_sum are new
//   peak_tag   - tag of the maximum-energy bin (held)
//   peak_sum   - energy of that bin (held)
//   drop_cnt   - saturating count of strobes seen while busy
//
// Modports:
//   slave  - the scheduler's view
//   master - the surrounding environment's view
// ---------------------------------------------------------------------------
interface fas_peak_scheduler_if #(
  parameter int NBINS = 16,
  parameter int SUM_W = 32
);
  logic                   fft_valid;
  logic                   fft_ready;
  logic                   buf_enable;
  logic                   buf_done;
  logic [NBINS*SUM_W-1:0] sum_bus;
  logic [NBINS*4-1:0]     tag_bus;
  logic                   peak_valid;
  logic [3:0]             peak_tag;
  logic [SUM_W-1:0]       peak_sum;
  logic [7:0]             drop_cnt;

  modport slave (
    input  fft_valid, buf_done, sum_bus, tag_bus,
    output fft_ready, buf_enable, peak_valid, peak_tag, peak_sum, drop_cnt
  );

  modport master (
    output fft_valid, buf_done, sum_bus, tag_bus,
    input  fft_ready, buf_enable, peak_valid, peak_tag, peak_sum, drop_cnt
  );
endinterface

// File: rtl/fas_peak_scheduler.sv
// ---------------------------------------------------------------------------
// fas_peak_scheduler
// Sequencing controller for the FAS magnitude stage. Accepts an FFT frame
// strobe, pulses the buffer array enable, waits for its done flag, then
// walks the 16 sum/tag pairs through one shared comparator to find the
// peak-energy bin and reports it with a one-cycle valid pulse.
//
// Ports:
//   i_clk  - system clock, all logic on posedge
//   i_rst  - synchronous active-high reset
//   io_bus - fas_peak_scheduler_if slave modport (handshake, buffer bus,
//            peak result, drop counter)
// ---------------------------------------------------------------------------
module fas_peak_scheduler #(
  parameter int NBINS = 16,
  parameter int SUM_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fas_peak_scheduler_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENA,
    S_WAIT,
    S_SCAN,
    S_REPORT
  } state_t;

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [SUM_W-1:0] r_best_sum;
  logic [3:0]       r_best_tag;
  logic             r_buf_enable;
  logic             r_peak_valid;
  logic [3:0]       r_peak_tag;
  logic [SUM_W-1:0] r_peak_sum;
  logic [7:0]       r_drop_cnt;

  logic [SUM_W-1:0] w_sum_sel;
  logic [3:0]       w_tag_sel;
  logic             w_take;
  logic [SUM_W-1:0] w_next_sum;
  logic [3:0]       w_next_tag;

  // The single shared comparator: a 16:1 mux on the scan index feeds one
  // strict unsigned compare. Strict ">" keeps the earlier (lower) bin on ties.
  always_comb begin
    w_sum_sel  = io_bus.sum_bus[r_idx*SUM_W +: SUM_W];
    w_tag_sel  = io_bus.tag_bus[r_idx*4 +: 4];
    w_take     = (w_sum_sel > r_best_sum);
    w_next_sum = w_take ? w_sum_sel : r_best_sum;
    w_next_tag = w_take ? w_tag_sel : r_best_tag;
  end

  // Main controller. All outputs except fft_ready are registered here. The
  // result registers are loaded on the last SCAN compare so the valid pulse
  // lines up with the REPORT state. drop_cnt counts strobes rejected while
  // busy and sticks at 255 until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_best_sum   <= '0;
      r_best_tag   <= '0;
      r_buf_enable <= 1'b0;
      r_peak_valid <= 1'b0;
      r_peak_tag   <= '0;
      r_peak_sum   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_buf_enable <= 1'b0;
      r_peak_valid <= 1'b0;

      if (io_bus.fft_valid && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (io_bus.fft_valid) begin
            r_state      <= S_ENA;
            r_buf_enable <= 1'b1;
          end
        end
        S_ENA: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Bin 0 seeds the running best so the scan only needs 15 compares.
          if (io_bus.buf_done) begin
            r_best_sum <= io_bus.sum_bus[SUM_W-1:0];
            r_best_tag <= io_bus.tag_bus[3:0];
            r_idx      <= 4'd1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_best_sum <= w_next_sum;
          r_best_tag <= w_next_tag;
          r_idx      <= r_idx + 4'd1;
          if (r_idx == 4'(NBINS - 1)) begin
            r_state      <= S_REPORT;
            r_peak_valid <= 1'b1;
            r_peak_tag   <= w_next_tag;
            r_peak_sum   <= w_next_sum;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // fft_ready is the only decoded output; everything else comes straight
  // from a register.
  always_comb begin
    io_bus.fft_ready  = (r_state == S_IDLE);
    io_bus.buf_enable = r_buf_enable;
    io_bus.peak_valid = r_peak_valid;
    io_bus.peak_tag   = r_peak_tag;
    io_bus.peak_sum   = r_peak_sum;
    io_bus.drop_cnt   = r_drop_cnt;
  end

endmodule

// File: tb/tb_fas_peak_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fas_peak_scheduler
// Scoreboard bench for fas_peak_scheduler. The driver steps one cycle at a
// time, acts as the buffer array (raises done a chosen number of cycles
// after the enable), and on each accepted frame pushes the expected enable
// cycle and the expected peak (cycle, tag, sum) into queues. A separate
// monitor pops and compares whenever the DUT pulses buf_enable/peak_valid,
// and checks fft_ready, drop_cnt and the held peak registers every cycle.
// ---------------------------------------------------------------------------
module tb_fas_peak_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fas_peak_scheduler_if bus ();

  fas_peak_scheduler dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  typedef struct {
    int         at;
    logic [3:0]  tag;
    logic [31:0] sum;
  } peakExp_t;

  peakExp_t    expPeak[$];
  int          expEna[$];

  int          cyc       = 0;
  int          total     = 0;
  int          bad       = 0;
  int          idleFrom  = 0;
  int          doneCycle = -1;
  int          mDrop     = 0;
  int          rstCycle  = -10;
  bit          monEn     = 1'b0;

  logic [31:0] frameSum[16];
  logic [3:0]  frameTag[16];
  logic [3:0]  heldTag = '0;
  logic [31:0] heldSum = '0;

  // Cycle counter: cycle n is the interval after the n-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, wanted %0h", name, cyc, act, exp);
    end
  endtask

  // Reference peak: find the maximum energy, then the first bin holding it.
  task automatic refPeak(output logic [3:0] tag, output logic [31:0] sum);
    logic [31:0] maxV;
    maxV = 32'd0;
    foreach (frameSum[k]) if (frameSum[k] > maxV) maxV = frameSum[k];
    tag = 4'd0;
    for (int k = 15; k >= 0; k--) if (frameSum[k] == maxV) tag = frameTag[k];
    sum = maxV;
  endtask

  // One cycle of stimulus. A frame is accepted when the model says the
  // scheduler is idle; done comes back 2+delay cycles later, the peak 16
  // cycles after done, and the block is idle again the cycle after that.
  task automatic applyStimulus(input logic v, input int delay);
    logic [3:0]  t;
    logic [31:0] s;
    @(negedge clk);
    rst           = 1'b0;
    bus.buf_done  = (cyc == doneCycle);
    bus.fft_valid = v;
    if (v) begin
      if (cyc >= idleFrom) begin
        for (int k = 0; k < 16; k++) begin
          bus.sum_bus[32*k +: 32] = frameSum[k];
          bus.tag_bus[4*k +: 4]   = frameTag[k];
        end
        refPeak(t, s);
        expEna.push_back(cyc + 1);
        expPeak.push_back('{cyc + 18 + delay, t, s});
        doneCycle = cyc + 2 + delay;
        idleFrom  = cyc + 19 + delay;
      end else if (mDrop < 255) begin
        mDrop++;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst           = 1'b1;
    bus.fft_valid = 1'b0;
    bus.buf_done  = 1'b0;
    expPeak.delete();
    expEna.delete();
    doneCycle = -1;
    idleFrom  = cyc + 1;
    mDrop     = 0;
    rstCycle  = cyc;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0);
  endtask

  task automatic setFrame(input int mode);
    for (int k = 0; k < 16; k++) begin
      frameTag[k] = 4'(k);
      case (mode)
        0: frameSum[k] = (k == 9) ? 32'h0001_0000 : 32'h100;
        1: frameSum[k] = (k == 3 || k == 12) ? 32'hFFFF_FFFF : 32'h0;
        2: frameSum[k] = 32'h0;
        3: frameSum[k] = 32'(k + 1);
        4: begin
          frameSum[k] = 32'($urandom_range(0, 3));
          frameTag[k] = 4'($urandom_range(0, 15));
        end
        default: begin
          frameSum[k] = $urandom;
          frameTag[k] = 4'($urandom_range(0, 15));
        end
      endcase
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    peakExp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (monEn) begin
        if (cyc == rstCycle + 1) begin
          heldTag = '0;
          heldSum = '0;
        end
        checkOutput("fft_ready", 64'(bus.fft_ready), 64'(cyc >= idleFrom));
        checkOutput("drop_cnt", 64'(bus.drop_cnt), 64'(mDrop));

        if (bus.buf_enable) begin
          if (expEna.size() == 0) checkOutput("buf_enable_spurious", 64'(bus.buf_enable), 64'd0);
          else checkOutput("buf_enable_cycle", 64'(cyc), 64'(expEna.pop_front()));
        end else if (expEna.size() > 0 && expEna[0] <= cyc) begin
          checkOutput("buf_enable_missing", 64'(bus.buf_enable), 64'd1);
          void'(expEna.pop_front());
        end

        if (bus.peak_valid) begin
          if (expPeak.size() == 0) begin
            checkOutput("peak_valid_spurious", 64'(bus.peak_valid), 64'd0);
          end else begin
            e = expPeak.pop_front();
            checkOutput("peak_cycle", 64'(cyc), 64'(e.at));
            heldTag = e.tag;
            heldSum = e.sum;
          end
        end else if (expPeak.size() > 0 && expPeak[0].at <= cyc) begin
          checkOutput("peak_valid_missing", 64'(bus.peak_valid), 64'd1);
          e = expPeak.pop_front();
          heldTag = e.tag;
          heldSum = e.sum;
        end
        checkOutput("peak_tag", 64'(bus.peak_tag), 64'(heldTag));
        checkOutput("peak_sum", 64'(bus.peak_sum), 64'(heldSum));
      end
    end
  end

  // Driver
  initial begin
    bus.fft_valid = 1'b0;
    bus.buf_done  = 1'b0;
    bus.sum_bus   = '0;
    bus.tag_bus   = '0;
    repeat (3) @(negedge clk);
    monEn = 1'b1;
    idleCycles(2);

    // Single peak, tie at the maximum value, all-zero frame, last-bin peak.
    for (int m = 0; m < 4; m++) begin
      setFrame(m);
      applyStimulus(1'b1, 0);
      idleCycles(22);
    end

    // Busy drop: 38 cycles of continuous strobes, two frames accepted.
    setFrame(5);
    for (int i = 0; i < 38; i++) applyStimulus(1'b1, 0);
    idleCycles(5);

    // Reset in the middle of a scan, then a clean frame.
    setFrame(0);
    applyStimulus(1'b1, 0);
    idleCycles(9);
    applyReset();
    setFrame(3);
    applyStimulus(1'b1, 0);
    idleCycles(22);

    // Delayed done.
    setFrame(5);
    applyStimulus(1'b1, 5);
    idleCycles(28);

    // Random strobes, delays and frame contents (small range forces ties).
    for (int i = 0; i < 400; i++) begin
      if (cyc >= idleFrom) setFrame($urandom_range(0, 1) == 0 ? 4 : 5);
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 4)));
    end
    idleCycles(30);

    // Saturation of the drop counter.
    setFrame(5);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 0);
    idleCycles(30);

    checkOutput("pending_enables", 64'(expEna.size()), 64'd0);
    checkOutput("pending_peaks", 64'(expPeak.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
